ultrasonic_scan_sched: RTL and testbench

//   Round-robin scheduler that shares one ping timeline across NUM_CH ultrasonic rangers.
//   Per ping: raises one channel's trig, times its echo pulse, reports the result, then

---
 rtl/ultrasonic_pkg.sv | 21 ++
 rtl/ultrasonic_rr_pick.sv | 31 +++
 rtl/ultrasonic_scan_sched.sv | 179 +++++++++++++++++
 tb/tb_ultrasonic_scan_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger scan scheduler.
// Holds the FSM state encoding, the channel-index width helper and the timeout marker value.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GAP
    } state_t;

    // Reported distance on timeout; sliced down to the counter width by users.
    localparam logic [31:0] DIST_TIMEOUT = 32'hFFFF_FFFF;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_rr_pick.sv
// Combinational round-robin finder: first set mask bit strictly after last_ch, wrapping back to last_ch itself.
// Zero latency; any=0 when the mask is empty.
module ultrasonic_rr_pick
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   last_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              any
);

    logic [CH_W-1:0] cand;

    // Walk from the farthest offset to the nearest so the nearest set bit wins.
    always_comb begin
        next_ch = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last_ch) + i) % NUM_CH);
            if (mask[cand]) begin
                next_ch = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ultrasonic_scan_sched.sv
// Round-robin ping scheduler for NUM_CH rangers; ULTRASONIC_SCHED_RESULTS_EN adds dist_all/timeout_all.
// Result strobes one cycle after the synced echo falls or the timer expires; no backpressure, dist_valid is a pulse.
module ultrasonic_scan_sched
    import ultrasonic_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  TRIG_US    = 10,
    parameter int  TIMEOUT_US = 30000,
    parameter int  GAP_US     = 60000,
    parameter int  CNT_W      = 16,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [NUM_CH-1:0]       echo,
    output logic [NUM_CH-1:0]       trig,
    output logic                    busy,
    output logic                    dist_valid,
    output logic [CH_W-1:0]         dist_ch,
    output logic [CNT_W-1:0]        dist_us,
    output logic                    dist_timeout
`ifdef ULTRASONIC_SCHED_RESULTS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] dist_all,
    output logic [NUM_CH-1:0]       timeout_all
`endif
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
    // GAP plus the IDLE pick cycle together span GAP_US cycles between REPORT and the next trig.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 2);
    localparam logic [CNT_W-1:0] TMO_DIST  = DIST_TIMEOUT[CNT_W-1:0];

    state_t            state;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   last_ch;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  dist_cnt;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic              echo_cur;
    logic              echo_d;
    logic              pick_any;
    logic [CH_W-1:0]   pick_ch;
    logic              echo_rise;
    logic              fin_echo;
    logic              fin_tmo;
    logic              rep_go;
    logic [CNT_W-1:0]  rep_us;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ultrasonic_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .mask    (ch_mask),
        .last_ch (last_ch),
        .next_ch (pick_ch),
        .any     (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
        end
    end

    assign echo_cur  = sync2[cur_ch];
    // echo_d tracks the active channel through TRIG, so a level already high on WAIT_RISE entry is no edge.
    assign echo_rise = echo_cur && !echo_d;

    always_comb begin
        fin_echo = (state == MEASURE) && !echo_cur;
        fin_tmo  = ((state == WAIT_RISE) || (state == MEASURE)) && (timer == TMO_LAST) && !fin_echo;
        rep_go   = fin_echo || fin_tmo;
        rep_us   = fin_tmo ? TMO_DIST : dist_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cur_ch       <= '0;
            last_ch      <= CH_W'(NUM_CH - 1);
            phase_cnt    <= '0;
            timer        <= '0;
            dist_cnt     <= '0;
            echo_d       <= 1'b0;
            trig         <= '0;
            busy         <= 1'b0;
            dist_valid   <= 1'b0;
            dist_ch      <= '0;
            dist_us      <= '0;
            dist_timeout <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            echo_d     <= echo_cur;
            case (state)
                IDLE: begin
                    if (enable && pick_any) begin
                        cur_ch    <= pick_ch;
                        trig      <= NUM_CH'(1) << pick_ch;
                        phase_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= TRIG;
                    end
                end
                TRIG: begin
                    if (phase_cnt == TRIG_LAST) begin
                        trig  <= '0;
                        timer <= '0;
                        state <= WAIT_RISE;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                WAIT_RISE, MEASURE: begin
                    timer <= sat_inc(timer);
                    if (rep_go) begin
                        dist_valid   <= 1'b1;
                        dist_ch      <= cur_ch;
                        dist_us      <= rep_us;
                        dist_timeout <= fin_tmo;
                        last_ch      <= cur_ch;
                        state        <= REPORT;
                    end else if (state == WAIT_RISE) begin
                        if (echo_rise) begin
                            // The edge cycle itself is the first high cycle of the pulse.
                            dist_cnt <= CNT_W'(1);
                            state    <= MEASURE;
                        end
                    end else begin
                        dist_cnt <= sat_inc(dist_cnt);
                    end
                end
                REPORT: begin
                    phase_cnt <= '0;
                    state     <= GAP;
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                default: begin
                    trig  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ULTRASONIC_SCHED_RESULTS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dist_all    <= '0;
            timeout_all <= '0;
        end else if (rep_go) begin
            dist_all[int'(cur_ch)*CNT_W +: CNT_W] <= rep_us;
            timeout_all[cur_ch]                   <= fin_tmo;
        end
    end
`endif

endmodule

// File: tb/tb_ultrasonic_scan_sched.sv
// Randomized bench for ultrasonic_scan_sched against a ping-level timeline model.
`timescale 1ns/1ps
module tb_ultrasonic_scan_sched;

    localparam int NUM_CH     = 4;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 700;
    localparam int GAP_US     = 30;
    localparam int CNT_W      = 16;
    localparam int CH_W       = 2;
    localparam int SYNC_LAT   = 2;
    localparam int TMO_VAL    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] trig;
    logic              busy;
    logic              dist_valid;
    logic [CH_W-1:0]   dist_ch;
    logic [CNT_W-1:0]  dist_us;
    logic              dist_timeout;
`ifdef ULTRASONIC_SCHED_RESULTS_EN
    logic [NUM_CH*CNT_W-1:0] dist_all;
    logic [NUM_CH-1:0]       timeout_all;
`endif

    always #5 clk = ~clk;

    ultrasonic_scan_sched #(
        .NUM_CH     (NUM_CH),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TIMEOUT_US),
        .GAP_US     (GAP_US),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .echo         (echo),
        .trig         (trig),
        .busy         (busy),
        .dist_valid   (dist_valid),
        .dist_ch      (dist_ch),
        .dist_us      (dist_us),
        .dist_timeout (dist_timeout)
`ifdef ULTRASONIC_SCHED_RESULTS_EN
        ,
        .dist_all     (dist_all),
        .timeout_all  (timeout_all)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Ping model: one ping is a trig window, an echo scenario and a predicted report cycle.
    bit ping_on = 1'b0;
    int rise, n_f, rep_cyc, p_ch, pc;
    int mode, d, h, d1, d2;
    int exp_us;
    bit exp_to;
    int last_m;
    int h_ch, h_us;
    bit h_to;
    int m_all[NUM_CH];
    bit m_to[NUM_CH];
    bit rst_prev;
    int rst_at = -100, en_low_from = 0, en_low_until = 0, zero_until = 0;
    bit zero_done = 1'b0;
    logic [NUM_CH-1:0] rnd_mask = '1;
    logic [NUM_CH-1:0] exp_trig;
    bit exp_dv;

    function automatic int rr_next(input int last, input logic [NUM_CH-1:0] m);
        for (int i = 1; i <= NUM_CH; i++) begin
            if (((m >> ((last + i) % NUM_CH)) & NUM_CH'(1)) != '0)
                return (last + i) % NUM_CH;
        end
        return -1;
    endfunction

    // Pin level of the active channel, k cycles after trig fall.
    function automatic bit scen_echo(input int k);
        case (mode)
            0:       return 1'b0;
            1:       return (k >= d) && (k < d + h);
            2:       return (k < d1) || ((k >= d2) && (k < d2 + h));
            default: return 1'b1;
        endcase
    endfunction

    task automatic predict_result();
        int rk;
        rk = (mode == 1) ? d : (mode == 2) ? d2 : -1;
        // The synced fall must be seen while the timer is still below TIMEOUT_US.
        if (rk >= 0 && rk + h + SYNC_LAT <= TIMEOUT_US - 1) begin
            rep_cyc = n_f + rk + h + SYNC_LAT + 1;
            exp_us  = h;
            exp_to  = 1'b0;
        end else begin
            rep_cyc = n_f + TIMEOUT_US;
            exp_us  = TMO_VAL;
            exp_to  = 1'b1;
        end
    endtask

    initial begin
        rstn     = 1'b0;
        enable   = 1'b1;
        ch_mask  = '1;
        echo     = '0;
        rst_prev = 1'b0;
        pc       = 0;
        last_m   = NUM_CH - 1;
        while (cyc < 90000 && !(pc >= 48 && !ping_on)) begin
            @(posedge clk);
            #1;
            cyc++;

            if (!rst_prev) begin
                ping_on = 1'b0;
                last_m  = NUM_CH - 1;
                h_ch = 0; h_us = 0; h_to = 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    m_all[c] = 0;
                    m_to[c]  = 1'b0;
                end
            end
            if (ping_on && cyc == rep_cyc + GAP_US)
                ping_on = 1'b0;

            exp_trig = (ping_on && cyc < rise + TRIG_US) ? NUM_CH'(1 << p_ch) : '0;
            exp_dv   = ping_on && (cyc == rep_cyc);
            if (exp_dv) begin
                h_ch = p_ch; h_us = exp_us; h_to = exp_to;
                last_m = p_ch;
                m_all[p_ch] = exp_us;
                m_to[p_ch]  = exp_to;
            end

            check("trig",         64'(trig),         64'(exp_trig));
            check("busy",         64'(busy),         64'(ping_on));
            check("dist_valid",   64'(dist_valid),   64'(exp_dv));
            check("dist_ch",      64'(dist_ch),      64'(h_ch));
            check("dist_us",      64'(dist_us),      64'(h_us));
            check("dist_timeout", 64'(dist_timeout), 64'(h_to));
`ifdef ULTRASONIC_SCHED_RESULTS_EN
            for (int c = 0; c < NUM_CH; c++) begin
                check("dist_all",    64'(dist_all[c*CNT_W +: CNT_W]), 64'(m_all[c]));
                check("timeout_all", 64'(timeout_all[c]),             64'(m_to[c]));
            end
`endif

            // Drive inputs for this cycle.
            if (!ping_on && pc == 26 && !zero_done) begin
                zero_done  = 1'b1;
                zero_until = cyc + 150;
            end
            if (pc >= 37 && cyc >= en_low_until && $urandom_range(0, 399) == 0) begin
                en_low_from  = cyc;
                en_low_until = cyc + int'($urandom_range(20, 300));
            end
            if ($urandom_range(0, 149) == 0)
                rnd_mask = NUM_CH'($urandom);

            rstn   = (cyc >= 3) && (cyc != rst_at) && (cyc != rst_at + 1);
            enable = !(cyc >= en_low_from && cyc < en_low_until);
            if (pc < 12)                  ch_mask = 4'b1111;
            else if (pc < 18)             ch_mask = 4'b0101;
            else if (pc < 22)             ch_mask = 4'b0100;
            else if (pc >= 33 && pc < 37) ch_mask = 4'b1111;
            else                          ch_mask = rnd_mask;
            if (cyc < zero_until)
                ch_mask = '0;

            echo = NUM_CH'($urandom);
            if (ping_on && cyc <= rep_cyc)
                echo[CH_W'(p_ch)] = scen_echo(cyc - n_f);

            if (!ping_on && rstn && enable && ch_mask != '0) begin
                p_ch = rr_next(last_m, ch_mask);
                rise = cyc + 1;
                n_f  = rise + TRIG_US;
                mode = int'($urandom_range(0, 3));
                d    = int'($urandom_range(0, 300));
                h    = int'($urandom_range(1, 600));
                d1   = int'($urandom_range(0, 150));
                d2   = d1 + int'($urandom_range(1, 150));
                if (pc < 5) mode = 0;
                if (pc == 5) begin
                    mode = 1; d = 100; h = 580;
                end
                if (pc == 21) begin
                    mode = 1; d = 50; h = 200;
                end
                predict_result();
                if (pc == 21) begin
                    en_low_from  = n_f + d + 5;
                    en_low_until = rep_cyc + GAP_US + 100;
                end
                if (pc == 35)
                    rst_at = rise + 4;
                ping_on = 1'b1;
                pc++;
            end
            rst_prev = rstn;
        end
        check("pings_done", 64'(pc >= 48), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
